i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
//  I2C target (responder) with an internal byte register file.
//  Opposite end of the GPIO bit-banged I2C initiator used on the audio/DDC buses.
//  Serves as the codec-side register model for FPGA loopback and as a CPU-visible control target.
//  Drives SDA open-drain only (pull-low enable); SCL is input-only (no clock stretching).
// PARAMETERS
//  DEV_ADDR     7'h1A  7-bit target address (write byte 0x34, read byte 0x35)
//  NR_REGS      16     register count, power of 2, 2..256
//  FILTER_LEN   3      clk cycles a synced SCL/SDA level must be stable before it is accepted
//  HOLD_CYCLES  4      clk cycles after filtered SCL fall before sda_oe may change
// PORTS
//  clk          in   1             system clock, all logic
//  reset_       in   1             asynchronous, active-low reset
//  scl_in       in   1             raw SCL pad level
//  sda_in       in   1             raw SDA pad level
//  sda_oe       out  1             1 = pull SDA low
//  wr_stb       out  1             1-cycle pulse when a register byte is written
//  wr_addr      out  8             register index of the write (valid with wr_stb)
//  wr_data      out  8             written byte (valid with wr_stb)
//  regs_flat    out  NR_REGS*8     register file, reg n at [n*8+7:n*8]
//  busy         out  1             1 from accepted START to STOP or address mismatch
// BEHAVIOUR
//  Reset (async): sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, all regs=0x00, ptr=0, state IDLE.
//  Input path: 2-flop sync, then filter; filtered level changes only after FILTER_LEN equal samples.
//   Total input latency is 2+FILTER_LEN cycles.
//  START: filtered SDA falls while SCL high. STOP: SDA rises while SCL high. Both are valid in any state.
//   START (incl. repeated) -> ADDR, bit count 0. STOP -> IDLE.
//   Either event sets sda_oe=0 in the same cycle it is detected.
//  Data bits are sampled on filtered SCL rise, MSB first.
//   sda_oe is updated only HOLD_CYCLES after filtered SCL fall.
//  States: IDLE, ADDR, ACK, PTR, WDATA, RDATA, RACK, WAIT.
//   ADDR: after 8 bits, if addr[7:1]==DEV_ADDR -> ACK (drive low for 9th clock), else WAIT with busy=0.
//    rw=addr[0]. After ACK, rw=0 -> PTR; rw=1 -> RDATA with regs[ptr] loaded.
//   PTR: byte < NR_REGS -> ptr=byte, ACK, then WDATA. Byte >= NR_REGS -> NACK (sda_oe stays 0), then WAIT.
//   WDATA: after 8 bits, on the 8th SCL rise: regs[ptr]=byte, wr_stb pulse, ACK.
//    Then ptr=(ptr+1) mod NR_REGS.
//   RDATA: drive ~bit (sda_oe=1 for a 0 bit) for 8 clocks, then release for 9th clock -> RACK.
//   RACK: sample SDA on 9th rise. 0 (ACK) -> ptr++ mod NR_REGS, load next byte, RDATA. 1 (NACK) -> WAIT.
//   WAIT: sda_oe=0; leave only on START/STOP.
//   ACK slot: sda_oe=1 from HOLD after 8th fall until HOLD after 9th fall, then 0 (or first read bit).
//  Boundaries:
//   - STOP/START mid-byte: partial byte discarded, no wr_stb.
//   - Pointer persists across transactions (reads without PTR use last ptr).
//   - wr_stb and a STOP in the same cycle: the write completes.
//   - Reset mid-transfer: sda_oe drops immediately (async) and SDA is released.
//   - SCL glitch shorter than FILTER_LEN cycles: no bit, no state change.
// STRUCTURE
//  Shared package: state encoding constants, I2C_RD/I2C_WR bit values, ACK=0/NACK=1.
//  Sub-module i2c_in_filter (2-flop sync + stability counter + rise/fall pulses), one instance per SCL and SDA.
//  Top: FSM, bit counter (0..8), shift register, ptr, register file, hold-delay counter.
// TESTING
//  1 Write 0x34,0x02,0xA5,0x5A,STOP -> 4 ACKs; regs[2]=A5, regs[3]=5A; wr_stb twice (addr 2, 3).
//  2 Write 0x34,0x02; repeated START; 0x35; read 2 bytes with ACK then NACK
//    -> bytes A5,5A; sda_oe=0 after NACK; busy=0 after STOP.
//  3 Address byte 0x40 then 3 data bytes -> all NACK; sda_oe never 1; no wr_stb; busy=0.
//  4 Pointer 0x0F, write 0x11,0x22 (NR_REGS=16) -> regs[15]=11, regs[0]=22; pointer 0x10 -> NACK, no write.
//  5 1-cycle low glitch on SCL and SDA mid-byte -> byte received unchanged; STOP after 4 bits -> no write, IDLE.
//  6 Assert reset_ while sda_oe=1 during read -> sda_oe=0 same cycle; all regs=0 after release.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared encodings for the I2C target
package i2c_target_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK,
      ST_PTR,
      ST_WDATA,
      ST_RDATA,
      ST_RACK,
      ST_WAIT
   } i2c_state_e;

   localparam logic I2C_WR   = 1'b0;
   localparam logic I2C_RD   = 1'b1;
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// rtl/i2c_in_filter.sv - pad synchroniser with stability filter and edge pulses
module i2c_in_filter #(
   parameter int   FILTER_LEN = 3,
   parameter logic RESET_VAL  = 1'b1
) (
   input  logic clk,
   input  logic reset_,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

   logic             sync1_q, sync2_q, level_q, rise_q, fall_q;
   logic [CNT_W-1:0] cnt_q;

   // The accepted level only moves once the synced level has disagreed for FILTER_LEN samples.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         sync1_q <= RESET_VAL;
         sync2_q <= RESET_VAL;
         level_q <= RESET_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            level_q <= sync2_q;
            rise_q  <= sync2_q;
            fall_q  <= ~sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with pointer-addressed byte register file
module i2c_target
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         NR_REGS     = 16,
   parameter int         FILTER_LEN  = 3,
   parameter int         HOLD_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset_,
   input  logic                 scl_in,
   input  logic                 sda_in,
   output logic                 sda_oe,
   output logic                 wr_stb,
   output logic [7:0]           wr_addr,
   output logic [7:0]           wr_data,
   output logic [NR_REGS*8-1:0] regs_flat,
   output logic                 busy
);

   localparam int         PTR_W    = $clog2(NR_REGS);
   localparam int         HOLD_W   = $clog2(HOLD_CYCLES + 1);
   localparam logic [8:0] NR_REGS9 = 9'(NR_REGS);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_in_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_scl_filt (
      .clk(clk), .reset_(reset_), .pin_i(scl_in),
      .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   i2c_in_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_sda_filt (
      .clk(clk), .reset_(reset_), .pin_i(sda_in),
      .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   i2c_state_e        state_q, ack_nxt_q;
   logic [3:0]        bit_cnt_q;
   logic [7:0]        shift_q;
   logic [PTR_W-1:0]  ptr_q;
   logic [HOLD_W-1:0] hold_q;
   logic [7:0]        regs_q [NR_REGS];
   logic              sda_oe_q, wr_stb_q, busy_q, ack_drive_q, ack_rise_q;
   logic [7:0]        wr_addr_q, wr_data_q;

   logic              start_det, stop_det, hold_done;
   logic [7:0]        byte_in;
   logic [PTR_W-1:0]  ptr_inc;

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;
   assign hold_done = (hold_q == HOLD_W'(1));
   assign byte_in   = {shift_q[6:0], sda_lvl};
   assign ptr_inc   = ptr_q + PTR_W'(1);

   // sda_oe only changes when hold_done fires, i.e. HOLD_CYCLES after a filtered SCL fall.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q     <= ST_IDLE;
         ack_nxt_q   <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         ptr_q       <= '0;
         hold_q      <= '0;
         sda_oe_q    <= 1'b0;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         ack_drive_q <= 1'b0;
         ack_rise_q  <= 1'b0;
         for (int i = 0; i < NR_REGS; i++) regs_q[i] <= '0;
      end else begin
         wr_stb_q <= 1'b0;
         if (scl_fall)         hold_q <= HOLD_W'(HOLD_CYCLES);
         else if (hold_q != 0) hold_q <= hold_q - 1'b1;

         if (start_det) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b1;
            hold_q    <= '0;
         end else if (stop_det) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            hold_q    <= '0;
         end else begin
            case (state_q)
               ST_ADDR, ST_PTR, ST_WDATA: begin
                  if (scl_rise) begin
                     shift_q   <= byte_in;
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == 4'd7) begin
                        bit_cnt_q   <= '0;
                        ack_rise_q  <= 1'b0;
                        ack_drive_q <= 1'b1;
                        state_q     <= ST_ACK;
                        case (state_q)
                           ST_ADDR: begin
                              if (byte_in[7:1] != DEV_ADDR) begin
                                 state_q <= ST_WAIT;
                                 busy_q  <= 1'b0;
                              end else if (byte_in[0] == I2C_RD) begin
                                 ack_nxt_q <= ST_RDATA;
                                 shift_q   <= regs_q[ptr_q];
                              end else begin
                                 ack_nxt_q <= ST_PTR;
                              end
                           end
                           ST_PTR: begin
                              if ({1'b0, byte_in} < NR_REGS9) begin
                                 ptr_q     <= PTR_W'(byte_in);
                                 ack_nxt_q <= ST_WDATA;
                              end else begin
                                 ack_drive_q <= 1'b0;
                                 ack_nxt_q   <= ST_WAIT;
                              end
                           end
                           default: begin
                              regs_q[ptr_q] <= byte_in;
                              wr_stb_q      <= 1'b1;
                              wr_addr_q     <= 8'(ptr_q);
                              wr_data_q     <= byte_in;
                              ptr_q         <= ptr_inc;
                              ack_nxt_q     <= ST_WDATA;
                           end
                        endcase
                     end
                  end
               end
               ST_ACK: begin
                  if (scl_rise) ack_rise_q <= 1'b1;
                  if (hold_done) begin
                     if (!ack_rise_q) begin
                        sda_oe_q <= ack_drive_q;
                     end else begin
                        state_q   <= ack_nxt_q;
                        bit_cnt_q <= '0;
                        sda_oe_q  <= (ack_nxt_q == ST_RDATA) ? ~shift_q[7] : 1'b0;
                     end
                  end
               end
               ST_RDATA: begin
                  if (scl_rise) begin
                     shift_q   <= {shift_q[6:0], 1'b0};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
                  if (hold_done) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= ST_RACK;
                     end else begin
                        sda_oe_q <= ~shift_q[7];
                     end
                  end
               end
               ST_RACK: begin
                  if (scl_rise) begin
                     if (sda_lvl == I2C_ACK) begin
                        ptr_q     <= ptr_inc;
                        shift_q   <= regs_q[ptr_inc];
                        bit_cnt_q <= '0;
                        state_q   <= ST_RDATA;
                     end else begin
                        state_q <= ST_WAIT;
                     end
                  end
               end
               ST_WAIT: sda_oe_q <= 1'b0;
               default: ;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NR_REGS; g++) begin : g_flat
      assign regs_flat[g*8 +: 8] = regs_q[g];
   end

   assign sda_oe  = sda_oe_q;
   assign wr_stb  = wr_stb_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed self-checking bench for i2c_target
module tb_i2c_target;

   localparam int Q = 20;

   logic         clk = 1'b0;
   logic         reset_ = 1'b0;
   logic         scl_m = 1'b1;
   logic         sda_m = 1'b1;
   logic         sda_oe, wr_stb, busy;
   logic [7:0]   wr_addr, wr_data;
   logic [127:0] regs_flat;
   logic         sda_line;

   int           checks = 0;
   int           errors = 0;
   int           wr_cnt = 0;
   int           oe_cnt = 0;
   logic [7:0]   wr_a_log [16];
   logic [7:0]   wr_d_log [16];

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target dut (
      .clk(clk), .reset_(reset_), .scl_in(scl_m), .sda_in(sda_line),
      .sda_oe(sda_oe), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
      .regs_flat(regs_flat), .busy(busy)
   );

   always @(negedge clk) begin
      if (wr_stb) begin
         if (wr_cnt < 16) begin
            wr_a_log[wr_cnt] = wr_addr;
            wr_d_log[wr_cnt] = wr_data;
         end
         wr_cnt++;
      end
      if (sda_oe) oe_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic do_start();
      sda_m = 1'b0; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic do_rstart();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic do_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q(); wait_q();
   endtask

   task automatic clk_bit(input logic b, input bit gl_scl, input bit gl_sda, output logic smp);
      sda_m = b; wait_q();
      scl_m = 1'b1; wait_q();
      if (gl_scl) begin scl_m = 1'b0; @(negedge clk); scl_m = 1'b1; end
      if (gl_sda) begin sda_m = 1'b0; @(negedge clk); sda_m = b; end
      smp = sda_line;
      wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0, 1'b0, s);
      clk_bit(1'b1, 1'b0, 1'b0, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(1'b1, 1'b0, 1'b0, d[i]);
      clk_bit(mack, 1'b0, 1'b0, s);
   endtask

   initial begin
      logic         ack, s, found;
      logic [7:0]   d;
      logic [7:0]   gbyte;
      logic [127:0] exp_regs;
      int           wr_base, oe_base;

      repeat (5) @(negedge clk);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_wr_stb", wr_stb, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_regs", regs_flat, 0);
      reset_ = 1'b1;
      wait_q();

      // 1: pointer write then two data bytes
      do_start();
      write_byte(8'h34, ack); check("t1_ack_addr", ack, 0);
      check("t1_busy", busy, 1);
      write_byte(8'h02, ack); check("t1_ack_ptr", ack, 0);
      write_byte(8'hA5, ack); check("t1_ack_d0", ack, 0);
      write_byte(8'h5A, ack); check("t1_ack_d1", ack, 0);
      do_stop();
      check("t1_busy_end", busy, 0);
      exp_regs = '0;
      exp_regs[2*8 +: 8] = 8'hA5;
      exp_regs[3*8 +: 8] = 8'h5A;
      check("t1_regs", regs_flat, exp_regs);
      check("t1_wr_cnt", wr_cnt, 2);
      check("t1_wr_a0", wr_a_log[0], 8'h02);
      check("t1_wr_d0", wr_d_log[0], 8'hA5);
      check("t1_wr_a1", wr_a_log[1], 8'h03);
      check("t1_wr_d1", wr_d_log[1], 8'h5A);

      // 2: set pointer, repeated START, read two bytes
      do_start();
      write_byte(8'h34, ack); check("t2_ack_addr", ack, 0);
      write_byte(8'h02, ack); check("t2_ack_ptr", ack, 0);
      do_rstart();
      write_byte(8'h35, ack); check("t2_ack_raddr", ack, 0);
      read_byte(1'b0, d); check("t2_rd0", d, 8'hA5);
      read_byte(1'b1, d); check("t2_rd1", d, 8'h5A);
      wait_q();
      check("t2_oe_after_nack", sda_oe, 0);
      do_stop();
      check("t2_busy_end", busy, 0);
      check("t2_wr_cnt", wr_cnt, 2);

      // 3: foreign address is ignored entirely
      oe_base = oe_cnt;
      wr_base = wr_cnt;
      do_start();
      write_byte(8'h40, ack); check("t3_nack_addr", ack, 1);
      check("t3_busy", busy, 0);
      write_byte(8'h01, ack); check("t3_nack_d0", ack, 1);
      write_byte(8'h77, ack); check("t3_nack_d1", ack, 1);
      write_byte(8'h88, ack); check("t3_nack_d2", ack, 1);
      do_stop();
      check("t3_oe_seen", oe_cnt - oe_base, 0);
      check("t3_no_wr", wr_cnt - wr_base, 0);
      check("t3_regs", regs_flat, exp_regs);

      // 4: pointer wraps at NR_REGS; out-of-range pointer is refused
      do_start();
      write_byte(8'h34, ack); check("t4_ack_addr", ack, 0);
      write_byte(8'h0F, ack); check("t4_ack_ptr", ack, 0);
      write_byte(8'h11, ack); check("t4_ack_d0", ack, 0);
      write_byte(8'h22, ack); check("t4_ack_d1", ack, 0);
      do_stop();
      exp_regs[15*8 +: 8] = 8'h11;
      exp_regs[0 +: 8]    = 8'h22;
      check("t4_regs_wrap", regs_flat, exp_regs);
      check("t4_wr_a_wrap", wr_a_log[3], 8'h00);
      do_start();
      write_byte(8'h34, ack); check("t4_ack_addr2", ack, 0);
      write_byte(8'h10, ack); check("t4_nack_ptr", ack, 1);
      write_byte(8'h77, ack); check("t4_nack_d", ack, 1);
      do_stop();
      check("t4_wr_cnt", wr_cnt, 4);
      check("t4_regs_kept", regs_flat, exp_regs);

      // 5: one-cycle glitches are filtered; STOP mid-byte discards it
      do_start();
      write_byte(8'h34, ack); check("t5_ack_addr", ack, 0);
      write_byte(8'h03, ack); check("t5_ack_ptr", ack, 0);
      gbyte = 8'h3C;
      for (int i = 7; i >= 0; i--) clk_bit(gbyte[i], (i == 3), (i == 5), s);
      clk_bit(1'b1, 1'b0, 1'b0, ack); check("t5_ack_glitch", ack, 0);
      exp_regs[3*8 +: 8] = 8'h3C;
      check("t5_regs_glitch", regs_flat, exp_regs);
      check("t5_wr_cnt", wr_cnt, 5);
      check("t5_wr_d", wr_d_log[4], 8'h3C);
      for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0, 1'b0, s);
      do_stop();
      check("t5_partial_no_wr", wr_cnt, 5);
      check("t5_busy", busy, 0);
      check("t5_regs_kept", regs_flat, exp_regs);

      // 6: asynchronous reset while the target pulls SDA low during a read
      do_start();
      write_byte(8'h34, ack); check("t6_ack_addr", ack, 0);
      write_byte(8'h02, ack); check("t6_ack_ptr", ack, 0);
      do_rstart();
      write_byte(8'h35, ack); check("t6_ack_raddr", ack, 0);
      clk_bit(1'b1, 1'b0, 1'b0, s); check("t6_bit7", s, 1);
      found = 1'b0;
      for (int i = 0; i < 4 * Q && !found; i++) begin
         if (sda_oe) found = 1'b1;
         else @(negedge clk);
      end
      check("t6_oe_driving", found, 1);
      #2 reset_ = 1'b0;
      #1 check("t6_oe_async", sda_oe, 0);
      check("t6_busy_async", busy, 0);
      wait_q();
      reset_ = 1'b1;
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
      check("t6_regs_cleared", regs_flat, 0);
      check("t6_busy_idle", busy, 0);
      check("t6_oe_idle", sda_oe, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
